// File: rtl/mii_tx_pkg.sv
// mii_tx_pkg: shared types and constants for the MII transmit framer and
// the CRC-32 nibble engine.
//   tx_state_t   - framer FSM states
//   PREAMBLE_NIB - preamble nibble value (4'h5)
//   SFD_NIB      - start-of-frame delimiter nibble (4'hD)
//   CRC_INIT     - CRC-32 register seed
//   CRC_POLY_REF - reflected IEEE 802.3 polynomial
//   CRC_RESIDUE  - good-frame residue (bit-reversed register after data+FCS)
package mii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY_REF = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

endpackage

// File: rtl/crc32_d4.sv
// crc32_d4: combinational next-state function of the reflected IEEE 802.3
// CRC-32 for one 4-bit data nibble (bit 0 is the first bit on the wire).
// Ports:
//   crc_in  - current CRC register
//   data    - nibble being transmitted/received
//   crc_out - CRC register after absorbing the nibble
module crc32_d4
  import mii_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REF;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/mii_tx_framer.sv
// mii_tx_framer: MII transmit framer. Takes client bytes on a valid/ready
// interface and drives TX_EN/TXD/TX_ER one nibble per clock: preamble + SFD,
// data (low nibble first), zero padding to MIN_FRAME, inverted CRC-32 FCS,
// then an inter-frame gap of 2*IFG_BYTES clocks.
// Ports:
//   phy_tx_clk   - MII TX clock, all logic on its rising edge
//   reset        - asynchronous active-low reset
//   tx_mac_data  - client byte, tx_mac_valid / tx_mac_last qualify it
//   tx_mac_ready - combinational accept strobe
//   phy_tx_en, phy_txd, phy_tx_err - registered MII pins
//   tx_busy      - high whenever the FSM is not idle
module mii_tx_framer
  import mii_tx_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic       phy_tx_clk,
  input  logic       reset,
  input  logic [7:0] tx_mac_data,
  input  logic       tx_mac_valid,
  input  logic       tx_mac_last,
  output logic       tx_mac_ready,
  output logic       phy_tx_en,
  output logic [3:0] phy_txd,
  output logic       phy_tx_err,
  output logic       tx_busy
);

  localparam int IFG_CYCLES = 2 * IFG_BYTES;
  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [10:0] PAD_LAST = 11'(MIN_FRAME - 1);

  tx_state_t        state, state_n;
  logic [3:0]       nib_cnt, nib_cnt_n;
  logic [10:0]      byte_cnt, byte_cnt_n, byte_cnt_inc;
  logic [IFG_W-1:0] ifg_cnt, ifg_cnt_n;
  logic [7:0]       byte_reg, byte_reg_n;
  logic             byte_last, byte_last_n;
  logic             nib_sel, nib_sel_n;
  logic             underrun, underrun_n;
  logic [31:0]      crc, crc_n, crc_calc, fcs;
  logic [3:0]       crc_nib;
  logic [3:0]       txd_n;
  logic             en_n, err_n;
  logic             accept;

  // The nibble fed to the CRC is exactly the one being sent in DATA/PAD;
  // it is derived outside the FSM block so the CRC path has no loop.
  assign crc_nib = (state == ST_PAD) ? 4'h0 : (nib_sel ? byte_reg[7:4] : byte_reg[3:0]);
  assign fcs     = ~crc;
  assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

  crc32_d4 u_crc (
    .crc_in  (crc),
    .data    (crc_nib),
    .crc_out (crc_calc)
  );

  // A new byte may only be taken while the high nibble of a non-last byte
  // is on the wire, so the byte register is reloaded just in time.
  assign tx_mac_ready = (state == ST_IDLE) ||
                        ((state == ST_DATA) && nib_sel && !byte_last && !underrun);
  assign accept  = tx_mac_valid && tx_mac_ready;
  assign tx_busy = (state != ST_IDLE);

  always_ff @(posedge phy_tx_clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      nib_cnt    <= 4'd0;
      byte_cnt   <= 11'd0;
      ifg_cnt    <= '0;
      byte_reg   <= 8'd0;
      byte_last  <= 1'b0;
      nib_sel    <= 1'b0;
      underrun   <= 1'b0;
      crc        <= CRC_INIT;
      phy_tx_en  <= 1'b0;
      phy_txd    <= 4'h0;
      phy_tx_err <= 1'b0;
    end else begin
      state      <= state_n;
      nib_cnt    <= nib_cnt_n;
      byte_cnt   <= byte_cnt_n;
      ifg_cnt    <= ifg_cnt_n;
      byte_reg   <= byte_reg_n;
      byte_last  <= byte_last_n;
      nib_sel    <= nib_sel_n;
      underrun   <= underrun_n;
      crc        <= crc_n;
      phy_tx_en  <= en_n;
      phy_txd    <= txd_n;
      phy_tx_err <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    nib_cnt_n   = nib_cnt;
    byte_cnt_n  = byte_cnt;
    ifg_cnt_n   = ifg_cnt;
    byte_reg_n  = byte_reg;
    byte_last_n = byte_last;
    nib_sel_n   = nib_sel;
    underrun_n  = underrun;
    crc_n       = crc;
    txd_n       = 4'h0;
    en_n        = 1'b0;
    err_n       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          byte_reg_n  = tx_mac_data;
          byte_last_n = tx_mac_last;
          byte_cnt_n  = 11'd1;
          nib_cnt_n   = 4'd0;
          nib_sel_n   = 1'b0;
          underrun_n  = 1'b0;
          crc_n       = CRC_INIT;
          state_n     = ST_PREAMBLE;
        end
      end

      ST_PREAMBLE: begin
        en_n      = 1'b1;
        txd_n     = (nib_cnt == 4'd15) ? SFD_NIB : PREAMBLE_NIB;
        nib_cnt_n = nib_cnt + 4'd1;
        if (nib_cnt == 4'd15) begin
          nib_sel_n = 1'b0;
          state_n   = ST_DATA;
        end
      end

      ST_DATA: begin
        en_n = 1'b1;
        if (underrun) begin
          // Client starved us: abort with a single TX_ER nibble, no FCS.
          err_n      = 1'b1;
          txd_n      = 4'h0;
          underrun_n = 1'b0;
          ifg_cnt_n  = '0;
          state_n    = ST_IFG;
        end else begin
          txd_n     = crc_nib;
          crc_n     = crc_calc;
          nib_sel_n = !nib_sel;
          if (nib_sel) begin
            if (byte_last) begin
              nib_cnt_n = 4'd0;
              state_n   = (byte_cnt < MIN_CNT) ? ST_PAD : ST_FCS;
            end else if (accept) begin
              byte_reg_n  = tx_mac_data;
              byte_last_n = tx_mac_last;
              byte_cnt_n  = byte_cnt_inc;
            end else begin
              underrun_n = 1'b1;
            end
          end
        end
      end

      ST_PAD: begin
        en_n      = 1'b1;
        txd_n     = 4'h0;
        crc_n     = crc_calc;
        nib_sel_n = !nib_sel;
        if (nib_sel) begin
          byte_cnt_n = byte_cnt_inc;
          if (byte_cnt >= PAD_LAST) begin
            nib_cnt_n = 4'd0;
            state_n   = ST_FCS;
          end
        end
      end

      ST_FCS: begin
        en_n      = 1'b1;
        txd_n     = fcs[{nib_cnt[2:0], 2'b00} +: 4];
        nib_cnt_n = nib_cnt + 4'd1;
        if (nib_cnt[2:0] == 3'd7) begin
          ifg_cnt_n = '0;
          state_n   = ST_IFG;
        end
      end

      ST_IFG: begin
        if (ifg_cnt == IFG_LAST) state_n = ST_IDLE;
        else                     ifg_cnt_n = ifg_cnt + 1'b1;
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mii_tx_framer.sv
// tb_mii_tx_framer: self-checking bench for mii_tx_framer. A negedge monitor
// captures every TX_EN burst; a byte-level reference model builds the
// expected nibble stream (preamble, SFD, padded data, FCS) and the bench
// compares them, plus timing, IFG, underrun and reset checks.
module tb_mii_tx_framer;
  import mii_tx_pkg::*;

  localparam int IFG_BYTES = 12;
  localparam int MIN_FRAME = 60;

  logic       phy_tx_clk;
  logic       reset;
  logic [7:0] tx_mac_data;
  logic       tx_mac_valid;
  logic       tx_mac_last;
  logic       tx_mac_ready;
  logic       phy_tx_en;
  logic [3:0] phy_txd;
  logic       phy_tx_err;
  logic       tx_busy;

  mii_tx_framer #(.IFG_BYTES(IFG_BYTES), .MIN_FRAME(MIN_FRAME)) dut (
    .phy_tx_clk   (phy_tx_clk),
    .reset        (reset),
    .tx_mac_data  (tx_mac_data),
    .tx_mac_valid (tx_mac_valid),
    .tx_mac_last  (tx_mac_last),
    .tx_mac_ready (tx_mac_ready),
    .phy_tx_en    (phy_tx_en),
    .phy_txd      (phy_txd),
    .phy_tx_err   (phy_tx_err),
    .tx_busy      (tx_busy)
  );

  initial begin
    phy_tx_clk = 1'b0;
    forever #5 phy_tx_clk = ~phy_tx_clk;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] txq[$];
  logic [7:0] fb[$];
  logic [3:0] exp_nibs[$];
  logic [3:0] exp_a[$];
  logic [3:0] exp_b[$];

  // monitor state
  logic [3:0] cur_nibs[$];
  logic [3:0] frame_nibs[$];
  int cur_errs, cur_err_idx, frame_errs, frame_err_idx;
  int frame_cnt = 0;
  int cycle = 0;
  int fall_cycle = -100000;
  int last_gap = 0;
  int run = 0;
  int ready_low_run = -1;
  int err_outside = 0;
  bit run_active = 0;
  bit prev_en = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ CRC_POLY_REF) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  // Reference model: wire bytes = 7x55, D5, data zero-padded to MIN_FRAME,
  // then ~CRC LSB byte first; each byte goes out low nibble first.
  function automatic void buildExpected();
    logic [7:0]  wb[$];
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    for (int i = 0; i < 7; i++) wb.push_back(8'h55);
    wb.push_back(8'hD5);
    c = CRC_INIT;
    n = (fb.size() > MIN_FRAME) ? fb.size() : MIN_FRAME;
    for (int i = 0; i < n; i++) begin
      b = (i < fb.size()) ? fb[i] : 8'h00;
      wb.push_back(b);
      c = crcByte(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) wb.push_back(c[8*k +: 8]);
    exp_nibs.delete();
    foreach (wb[i]) begin
      exp_nibs.push_back(wb[i][3:0]);
      exp_nibs.push_back(wb[i][7:4]);
    end
  endfunction

  task automatic makeFrame(input int len, input logic [7:0] first, input bit rnd);
    logic [7:0] b;
    fb.delete();
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : first + 8'(i);
      fb.push_back(b);
      txq.push_back(b);
    end
    buildExpected();
  endtask

  // Send len bytes from txq; stop_after < len drops valid early (underrun).
  task automatic applyStimulus(input int len, input int stop_after);
    logic [7:0] bytes[$];
    int t, n;
    for (int i = 0; i < len; i++) bytes.push_back(txq.pop_front());
    n = (stop_after < len) ? stop_after : len;
    for (int i = 0; i < n; i++) begin
      @(negedge phy_tx_clk);
      tx_mac_valid = 1'b1;
      tx_mac_data  = bytes[i];
      tx_mac_last  = (i == len - 1);
      t = 0;
      while (!tx_mac_ready && t < 6000) begin
        @(negedge phy_tx_clk);
        t++;
      end
      if (!tx_mac_ready) begin
        checkOutput("send_ready_timeout", 0, 1);
        break;
      end
    end
    @(negedge phy_tx_clk);
    tx_mac_valid = 1'b0;
    tx_mac_last  = 1'b0;
  endtask

  task automatic waitFrame(input int prev, input int budget);
    int t = 0;
    while (frame_cnt == prev && t < budget) begin
      @(negedge phy_tx_clk);
      #1;
      t++;
    end
    if (frame_cnt == prev) checkOutput("frame_timeout", 0, 1);
  endtask

  task automatic checkStream(input string name);
    int bad = -1;
    int m;
    m = (frame_nibs.size() < exp_nibs.size()) ? frame_nibs.size() : exp_nibs.size();
    for (int i = 0; i < m; i++) begin
      if (frame_nibs[i] != exp_nibs[i]) begin
        bad = i;
        break;
      end
    end
    if (bad < 0 && frame_nibs.size() != exp_nibs.size()) bad = m;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s: stream differs at nibble %0d (got %0h, expected %0h), lengths %0d vs %0d",
               name, bad, (bad < frame_nibs.size()) ? frame_nibs[bad] : 4'h0,
               (bad < exp_nibs.size()) ? exp_nibs[bad] : 4'h0, frame_nibs.size(), exp_nibs.size());
    end
  endtask

  // Receiver view: CRC over everything after the SFD must leave the residue.
  function automatic logic [31:0] residueOf();
    logic [31:0] c;
    c = CRC_INIT;
    if (frame_nibs.size() < 18 || frame_nibs.size() % 2 != 0) return 32'd0;
    for (int i = 16; i < frame_nibs.size(); i += 2)
      c = crcByte(c, {frame_nibs[i+1], frame_nibs[i]});
    return rev32(c);
  endfunction

  // Burst capture, gap between bursts and ready-low run after each burst.
  initial begin
    forever begin
      @(negedge phy_tx_clk);
      cycle++;
      if (phy_tx_en) begin
        if (!prev_en) begin
          cur_nibs.delete();
          cur_errs    = 0;
          cur_err_idx = -1;
          last_gap    = cycle - fall_cycle;
        end
        if (phy_tx_err) begin
          cur_errs++;
          cur_err_idx = cur_nibs.size();
        end
        cur_nibs.push_back(phy_txd);
      end else begin
        if (phy_tx_err) err_outside++;
        if (prev_en) begin
          frame_nibs    = cur_nibs;
          frame_errs    = cur_errs;
          frame_err_idx = cur_err_idx;
          fall_cycle    = cycle;
          run_active    = 1;
          run           = 0;
          frame_cnt++;
        end
      end
      if (run_active) begin
        if (!tx_mac_ready) run++;
        else begin
          ready_low_run = run;
          run_active    = 0;
        end
      end
      prev_en = phy_tx_en;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int         len;
    logic [7:0] first;
    int         exp_en;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int prev, len;
    vecs[0] = '{1,   8'hAB, 144};
    vecs[1] = '{60,  8'h00, 144};
    vecs[2] = '{59,  8'h80, 144};
    vecs[3] = '{61,  8'h40, 146};
    vecs[4] = '{64,  8'hF0, 152};
    vecs[5] = '{100, 8'h11, 224};

    reset        = 1'b0;
    tx_mac_valid = 1'b0;
    tx_mac_last  = 1'b0;
    tx_mac_data  = 8'h00;
    #2;
    checkOutput("reset_tx_en",  phy_tx_en, 0);
    checkOutput("reset_txd",    phy_txd, 0);
    checkOutput("reset_tx_err", phy_tx_err, 0);
    checkOutput("reset_busy",   tx_busy, 0);
    checkOutput("reset_ready",  tx_mac_ready, 1);
    repeat (2) @(negedge phy_tx_clk);
    reset = 1'b1;

    $display("[TB] table-driven frames");
    for (int v = 0; v < 6; v++) begin
      makeFrame(vecs[v].len, vecs[v].first, 0);
      prev = frame_cnt;
      applyStimulus(vecs[v].len, vecs[v].len);
      waitFrame(prev, 3000);
      checkOutput($sformatf("tx_en_cycles_len%0d", vecs[v].len), frame_nibs.size(), vecs[v].exp_en);
      checkStream($sformatf("stream_len%0d", vecs[v].len));
      checkOutput($sformatf("fcs_residue_len%0d", vecs[v].len), residueOf(), CRC_RESIDUE);
    end

    $display("[TB] back-to-back 1514 + 64");
    makeFrame(1514, 8'h00, 1);
    exp_a = exp_nibs;
    makeFrame(64, 8'h00, 1);
    exp_b = exp_nibs;
    prev = frame_cnt;
    fork
      begin
        applyStimulus(1514, 1514);
        applyStimulus(64, 64);
      end
    join_none
    waitFrame(prev, 5000);
    checkOutput("b2b_first_tx_en_cycles", frame_nibs.size(), 3052);
    exp_nibs = exp_a;
    checkStream("b2b_first_stream");
    prev = frame_cnt;
    waitFrame(prev, 1000);
    checkOutput("b2b_second_tx_en_cycles", frame_nibs.size(), 152);
    exp_nibs = exp_b;
    checkStream("b2b_second_stream");
    checkOutput("b2b_gap", last_gap, 2 * IFG_BYTES + 1);
    // The first IFG cycle coincides with the last FCS nibble on the wire, so
    // the run of low-ready samples after the observed fall is one shorter.
    checkOutput("b2b_ifg_ready_low", ready_low_run, 2 * IFG_BYTES - 1);

    $display("[TB] underrun after 10 bytes of 100");
    makeFrame(100, 8'h20, 0);
    prev = frame_cnt;
    applyStimulus(100, 10);
    waitFrame(prev, 1000);
    repeat (30) @(negedge phy_tx_clk);
    #1;
    checkOutput("underrun_tx_en_cycles", frame_nibs.size(), 16 + 20 + 1);
    checkOutput("underrun_err_count", frame_errs, 1);
    checkOutput("underrun_err_index", frame_err_idx, 36);
    exp_nibs = exp_nibs[0:35];
    exp_nibs.push_back(4'h0);
    checkStream("underrun_stream");
    checkOutput("underrun_ifg_ready_low", ready_low_run, 2 * IFG_BYTES - 1);
    checkOutput("underrun_idle_after_gap", tx_busy, 0);
    checkOutput("underrun_no_new_burst", frame_cnt, prev + 1);

    $display("[TB] reset during FCS");
    makeFrame(60, 8'h33, 0);
    prev = frame_cnt;
    applyStimulus(60, 60);
    begin
      int t = 0;
      while (cur_nibs.size() < 16 + 120 + 3 && t < 500) begin
        @(negedge phy_tx_clk);
        #1;
        t++;
      end
    end
    checkOutput("pre_reset_tx_en", phy_tx_en, 1);
    reset = 1'b0;
    #1;
    checkOutput("async_reset_tx_en",  phy_tx_en, 0);
    checkOutput("async_reset_txd",    phy_txd, 0);
    checkOutput("async_reset_tx_err", phy_tx_err, 0);
    repeat (2) @(negedge phy_tx_clk);
    reset = 1'b1;
    #1;
    checkOutput("post_reset_ready", tx_mac_ready, 1);
    checkOutput("post_reset_busy",  tx_busy, 0);
    waitFrame(prev, 10);
    checkOutput("truncated_no_err", frame_errs, 0);
    makeFrame(70, 8'h00, 1);
    prev = frame_cnt;
    applyStimulus(70, 70);
    waitFrame(prev, 3000);
    checkOutput("post_reset_tx_en_cycles", frame_nibs.size(), 16 + 140 + 8);
    checkStream("post_reset_stream");

    $display("[TB] randomized frames");
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 100);
      makeFrame(len, 8'h00, 1);
      prev = frame_cnt;
      applyStimulus(len, len);
      waitFrame(prev, 3000);
      checkOutput($sformatf("rand%0d_tx_en_cycles", r), frame_nibs.size(),
                  16 + 2 * ((len > MIN_FRAME) ? len : MIN_FRAME) + 8);
      checkStream($sformatf("rand%0d_stream", r));
      checkOutput($sformatf("rand%0d_residue", r), residueOf(), CRC_RESIDUE);
      repeat ($urandom_range(0, 30)) @(negedge phy_tx_clk);
    end

    checkOutput("err_outside_tx_en", err_outside, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mii_tx_framer.md
# mii_tx_framer

MII transmit framer: accepts a byte stream from the MAC client on the `tx_mac_*` valid/ready interface and drives the PHY transmit pins `phy_tx_en`/`phy_txd`/`phy_tx_err` one nibble per `phy_tx_clk`. It generates the preamble and SFD, pads short frames, appends the CRC-32 FCS and enforces the inter-frame gap. It is the transmit-side counterpart of the MII receive path inside `mac_controller`, and a full-duplex MAC instantiates it beside that path.

## Interface
- `IFG_BYTES`, 12: inter-frame gap in byte times (2*IFG_BYTES clocks).
- `MIN_FRAME`, 60: minimum frame length, excluding FCS, in bytes; shorter frames are zero-padded up to it.
- `phy_tx_clk`  in  1  sole clock (2.5/25 MHz MII TX clock); every element is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_mac_data`  in  8  client byte (DA first).
- `tx_mac_valid`  in  1  `tx_mac_data` is valid.
- `tx_mac_last`  in  1  current byte is the last byte of the frame.
- `tx_mac_ready`  out  1  framer accepts the byte this cycle.
- `phy_tx_en`  out  1  MII TX_EN.
- `phy_txd`  out  4  MII TXD; low nibble of each byte is sent first.
- `phy_tx_err`  out  1  MII TX_ER.
- `tx_busy`  out  1  high in every state except IDLE.

## Operation
- A byte is transferred when `tx_mac_valid && tx_mac_ready` is true at a rising edge.
- `tx_mac_ready` is combinational and is high in two cases:
  - in IDLE;
  - in DATA, on the high-nibble cycle of the current byte, when that byte was not marked last.
- FSM states are IDLE, PREAMBLE, DATA, PAD, FCS, IFG.
- IDLE → PREAMBLE when a byte is accepted. The first byte is held in the byte register.
- PREAMBLE: 15 nibbles of 4'h5, then 1 nibble of 4'hD (SFD). Then go to DATA.
- DATA: send the low nibble, then the high nibble of the byte register.
  - At the high nibble, if the byte was last: go to PAD when the byte count is below MIN_FRAME, else go to FCS.
  - At the high nibble, if the byte was not last and no byte is accepted, this is an underrun. Drive `phy_tx_err`=1 with `phy_tx_en`=1 and `phy_txd`=4'h0 for one nibble, then go to IFG. No FCS is sent.
- PAD: 4'h0 nibbles until the byte count equals MIN_FRAME, then go to FCS.
- FCS: 8 nibbles of the inverted CRC, LSB nibble first (bits [3:0] first). Then go to IFG.
- IFG: `phy_tx_en`=0 for 2*IFG_BYTES cycles, then go to IDLE. `tx_mac_ready`=0 throughout IFG, and `tx_mac_valid` is ignored.
- CRC: IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320.
  - Init 0xFFFFFFFF at PREAMBLE entry.
  - Updated per transmitted nibble over DA..last data/pad byte.
  - Excludes preamble, SFD and FCS.
- Byte counter: 11 bits, saturates at 2047; only the comparison with MIN_FRAME is used. Frames longer than 1514 bytes are not truncated.

## Timing
- Registered outputs: `phy_tx_en`, `phy_txd`, `phy_tx_err`.
- Reset values: `phy_tx_en`=0, `phy_txd`=4'h0, `phy_tx_err`=0, `tx_busy`=0, `tx_mac_ready`=1 (IDLE).
- Start-up latency (first byte accepted at edge N):
  - `phy_tx_en` rises at N+1;
  - SFD 4'hD on `phy_txd` at N+16;
  - byte k low nibble at N+17+2k.
- `tx_mac_ready` is high at most every other cycle while in DATA.
- Frame on the wire: `phy_tx_en` is high for exactly 16 + 2*max(L, MIN_FRAME) + 8 cycles, where L is the client byte count.
- Frame spacing: the next `phy_tx_en` rise is no earlier than 2*IFG_BYTES + 1 cycles after the previous fall.
- Reset assertion mid-frame: outputs reach their reset values immediately (asynchronous) and the FSM returns to IDLE. No FCS or error nibble is emitted.
- `tx_mac_valid` and `tx_mac_last` asserted together on the first byte: a 1-byte frame, padded to MIN_FRAME.

## Structure
- Package `mii_tx_pkg` holds:
  - the FSM state enum;
  - `PREAMBLE_NIB`=4'h5, `SFD_NIB`=4'hD, `CRC_INIT`=32'hFFFFFFFF, `CRC_POLY_REF`=32'hEDB88320, `CRC_RESIDUE`=32'hC704DD7B.
- Sub-module `crc32_d4`: a purely combinational next-CRC function of the current CRC and a 4-bit data nibble, shared with the receive path.
- `mii_tx_framer` contains:
  - the FSM;
  - the preamble/FCS nibble counter (4 bits);
  - the byte counter;
  - the IFG counter;
  - the byte register with its nibble-select flag.

## Test plan
- Single byte 0xAB with `last`: `phy_txd` shows 4'h5 ×15, 4'hD, B, A, 118 × 4'h0, then 8 FCS nibbles. `phy_tx_en` is high for 144 cycles. The FCS matches the software CRC of {0xAB, 59×0x00}.
- 60-byte frame 0x00..0x3B: no pad, `phy_tx_en` high for 144 cycles. Receiver-side CRC over data+FCS equals the residue 0xC704DD7B.
- 1514-byte frame followed back-to-back by a 64-byte frame:
  - first burst: `phy_tx_en` high for 3052 cycles;
  - `tx_mac_ready` low for all 24 IFG cycles;
  - second preamble starts 25 cycles after the first fall.
- Underrun: `tx_mac_valid` dropped after byte 10 of a 100-byte frame. Exactly one nibble with `phy_tx_err`=1 and `phy_tx_en`=1, no FCS, then a 24-cycle gap.
- `reset` pulsed low during FCS: `phy_tx_en`, `phy_txd` and `phy_tx_err` go to 0 without waiting for a clock edge, and `tx_mac_ready`=1 after release. The next frame transmits correctly.
- Loopback of `phy_txd`/`phy_tx_en` into `mac_controller` `phy_rxd`/`phy_rx_dv` with DA 01_80_C2_00_00_01: `rx_stat_valid` pulses and `rx_mac_data` reproduces the sent bytes.
